// File: rtl/gray_pkg.sv
// Shared definitions for 3-bit Gray-code consumers.
package gray_pkg;

    localparam int unsigned GRAY_W = 3;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    function automatic logic [GRAY_W-1:0] gray2bin3(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin_3bit.sv
// Purely combinational 3-bit Gray to binary converter.
module gray_to_bin_3bit
    import gray_pkg::*;
(
    input  logic [GRAY_W-1:0] gray,
    output logic [GRAY_W-1:0] bin_c
);

    assign bin_c = gray2bin3(gray);

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks single-step movement of a Gray-coded level, keeping a signed
// running position and a sticky flag for illegal multi-step jumps.
module gray_step_tracker
    import gray_pkg::*;
#(
    parameter int unsigned POS_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [GRAY_W-1:0]       gray_in,
    input  logic                    clr_err,
    output logic [GRAY_W-1:0]       level,
    output logic signed [POS_W-1:0] pos,
    output logic                    step_up,
    output logic                    step_dn,
    output logic                    err,
    output logic                    tracking
);

    state_t              state;
    logic [GRAY_W-1:0]   bin_c;
    logic [GRAY_W-1:0]   delta_c;

    gray_to_bin_3bit u_conv (
        .gray  (gray_in),
        .bin_c (bin_c)
    );

    // Modulo-8 distance from the last accepted level.
    assign delta_c = GRAY_W'(bin_c - level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            level    <= '0;
            pos      <= '0;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            err      <= 1'b0;
            tracking <= 1'b0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            // Clear first so a same-cycle illegal jump wins.
            if (clr_err) begin
                err <= 1'b0;
            end
            case (state)
                INIT: begin
                    if (enable) begin
                        level    <= bin_c;
                        state    <= TRACK;
                        tracking <= 1'b1;
                    end
                end
                TRACK: begin
                    // Disabled encoder forces 000; re-reference instead of counting it.
                    if (!enable) begin
                        state    <= INIT;
                        tracking <= 1'b0;
                    end else begin
                        case (delta_c)
                            3'd0: begin
                            end
                            3'd1: begin
                                level   <= bin_c;
                                pos     <= pos + POS_W'(1);
                                step_up <= 1'b1;
                            end
                            3'd7: begin
                                level   <= bin_c;
                                pos     <= pos - POS_W'(1);
                                step_dn <= 1'b1;
                            end
                            default: begin
                                level <= bin_c;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    state    <= INIT;
                    tracking <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed bench for gray_step_tracker at POS_W=8 and POS_W=4.
module tb_gray_step_tracker;

    logic              clk;
    logic              rst_n;
    logic              enable_a, clr_err_a;
    logic [2:0]        gray_a;
    logic [2:0]        level_a;
    logic signed [7:0] pos_a;
    logic              up_a, dn_a, err_a, trk_a;

    logic              enable_b, clr_err_b;
    logic [2:0]        gray_b;
    logic [2:0]        level_b;
    logic signed [3:0] pos_b;
    logic              up_b, dn_b, err_b, trk_b;

    int n_checks;
    int n_fail;

    gray_step_tracker #(.POS_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .gray_in(gray_a),
        .clr_err(clr_err_a), .level(level_a), .pos(pos_a), .step_up(up_a),
        .step_dn(dn_a), .err(err_a), .tracking(trk_a)
    );

    gray_step_tracker #(.POS_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .gray_in(gray_b),
        .clr_err(clr_err_b), .level(level_b), .pos(pos_b), .step_up(up_b),
        .step_dn(dn_b), .err(err_b), .tracking(trk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic en, input logic [2:0] g, input logic clr);
        enable_a  = en;
        gray_a    = g;
        clr_err_a = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic state_a(input string tag, input int lv, input int p, input int up,
                           input int dn, input int er, input int tr);
        check({tag, ".level"}, int'(level_a), lv);
        check({tag, ".pos"}, int'(pos_a), p);
        check({tag, ".step_up"}, int'(up_a), up);
        check({tag, ".step_dn"}, int'(dn_a), dn);
        check({tag, ".err"}, int'(err_a), er);
        check({tag, ".tracking"}, int'(trk_a), tr);
    endtask

    initial begin
        logic [2:0] up_seq [6];
        logic [2:0] b_seq  [8];
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        enable_a  = 1'b0; gray_a = 3'b000; clr_err_a = 1'b0;
        enable_b  = 1'b0; gray_b = 3'b000; clr_err_b = 1'b0;
        up_seq = '{3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        b_seq  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        repeat (2) @(posedge clk);
        #1;
        state_a("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First enabled sample only references the level.
        step_a(1'b1, 3'b011, 1'b0);
        state_a("init", 2, 0, 0, 0, 0, 1);

        for (int i = 0; i < 6; i++) begin
            step_a(1'b1, up_seq[i], 1'b0);
            check($sformatf("up%0d.step_up", i), int'(up_a), 1);
            check($sformatf("up%0d.pos", i), int'(pos_a), i + 1);
        end
        state_a("after_ups", 0, 6, 1, 0, 0, 1);
        step_a(1'b1, 3'b000, 1'b0);
        state_a("hold0", 0, 6, 0, 0, 0, 1);

        step_a(1'b1, 3'b100, 1'b0);
        state_a("wrap_dn", 7, 5, 0, 1, 0, 1);
        step_a(1'b1, 3'b100, 1'b0);
        state_a("hold7", 7, 5, 0, 0, 0, 1);

        step_a(1'b1, 3'b001, 1'b0);
        state_a("illegal", 1, 5, 0, 0, 1, 1);
        step_a(1'b1, 3'b111, 1'b1);
        state_a("clr_vs_set", 5, 5, 0, 0, 1, 1);
        step_a(1'b1, 3'b111, 1'b1);
        state_a("clr", 5, 5, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 3'b000, 1'b0);
            state_a($sformatf("dis%0d", i), 5, 5, 0, 0, 0, 0);
        end
        step_a(1'b1, 3'b110, 1'b0);
        state_a("reenable", 4, 5, 0, 0, 0, 1);

        // Reset between edges must act immediately.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        state_a("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b1, 3'b010, 1'b0);
        state_a("post_rst", 3, 0, 0, 0, 0, 1);

        // Narrow counter wraps from +7 to -8.
        enable_b = 1'b1;
        gray_b   = 3'b000;
        @(posedge clk);
        #1;
        check("b.init.tracking", int'(trk_b), 1);
        for (int i = 0; i < 8; i++) begin
            gray_b = b_seq[i];
            @(posedge clk);
            #1;
            check($sformatf("b.up%0d.step_up", i), int'(up_b), 1);
        end
        check("b.wrap.pos", int'(pos_b), -8);
        check("b.wrap.level", int'(level_b), 0);
        check("b.wrap.err", int'(err_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_step_tracker.md
Name: gray_step_tracker

Overview:
- Sequential stage directly downstream of the 3-bit thermometer-to-Gray encoder.
- Registers the 3-bit Gray level every clock and converts it to binary.
- Classifies each change as a single step up, a single step down, or an illegal jump.
- Maintains a signed running position and a sticky error flag for the control/display logic that follows.

Parameters:
- POS_W, 8, width of signed two's-complement running position counter (min 4).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  same enable as the upstream encoder; 0 = upstream output forced to 000 and ignored here
- gray_in  in  3  Gray-coded level from the encoder
- clr_err  in  1  synchronous clear of err
- level  out  3  registered binary level of last accepted sample
- pos  out  POS_W  signed running position
- step_up  out  1  one-cycle pulse, level advanced by +1 (mod 8)
- step_dn  out  1  one-cycle pulse, level retreated by -1 (mod 8)
- err  out  1  sticky, set on any illegal jump
- tracking  out  1  1 when state = TRACK

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=INIT; level=0; pos=0; step_up=0; step_dn=0; err=0; tracking=0.
- Conversion: b[2]=g[2]; b[1]=g[2]^g[1]; b[0]=b[1]^g[0]; combinational, feeds the registered logic.
- Latency: gray_in sampled at edge N; level/pos/step_*/err reflect it after edge N (1 cycle).
- State INIT:
  - enable=1: level<=bin(gray_in); pos unchanged; no pulse; go TRACK.
  - enable=0: stay INIT; all outputs hold except pulses=0.
- State TRACK, enable=1: d = (bin(gray_in) - level) mod 8.
  - d=0: hold; pulses 0.
  - d=1: level<=new; pos<=pos+1; step_up=1.
  - d=7: level<=new; pos<=pos-1; step_dn=1.
  - d in 2..6: illegal; level<=new (resync); pos unchanged; err<=1; no pulse.
- State TRACK, enable=0: go INIT. level/pos hold; pulses 0. The forced 000 from the disabled encoder must never be counted as a jump.
- Wrap:
  - level 7->0 is a step up; 0->7 is a step down.
  - pos wraps modulo 2^POS_W (0x7F+1 -> 0x80 for POS_W=8); no saturation; no flag.
- step_up and step_dn are never both 1; each is high for exactly one cycle per step.
- err:
  - Set on illegal jump; cleared only by clr_err or reset.
  - clr_err and a new illegal jump in the same cycle -> err=1 (set wins).
- Reset asserted mid-operation: immediate return to reset values regardless of clk; first enabled cycle after release re-references (INIT).
- gray_in X/unknown is not handled; the upstream encoder guarantees a defined value.

Decomposition:
- Shared package gray_pkg:
  - state enum {INIT, TRACK};
  - constant GRAY_W=3;
  - function gray2bin3 (also reused by future Gray consumers).
- One natural sub-module: gray_to_bin_3bit (pure combinational converter), instantiated once. Step classification, pos counter and err live in the top.

Test Plan:
- Reset then enable=1, gray_in=011 (bin 2) -> after 1 edge: tracking=1, level=2, pos=0, no pulse.
- From level 2, gray sequence 010,110,111,101,100,000 (bin 3,4,5,6,7,0) -> six step_up pulses, pos=6, level=0 (7->0 wrap counts up).
- From level 0, gray_in=100 (bin 7) -> step_dn=1 for one cycle, pos decrements by 1, level=7.
- From level 7, gray_in=001 (bin 1, d=2) -> err=1, level=1, pos unchanged, no pulse. Then clr_err together with jump to gray 111 (bin 5) -> err stays 1. clr_err alone next cycle -> err=0.
- enable=0 for 3 cycles with gray_in=000, then enable=1 with gray_in=110 (bin 4) -> no pulses, no err, level=4, pos unchanged.
- POS_W=4, pos=7, one step up -> pos=-8 (1000). Async rst_n pulse between edges -> all outputs 0 immediately, tracking=0.
